dif_bfu: RTL and testbench

- Pipelined radix-2 decimation-in-frequency (Gentleman-Sande) butterfly, the inverse-direction counterpart of the DIT butterfly.
- Computes A' = A + B and B' = (A − B)·W, where W is conjugated when inverse=1.
- Supports optional per-stage ÷2 scaling and saturation, with a sticky overflow flag.
- Used by the IFFT/DIF stage datapath; it takes the same complex_t operands as the forward BFU, with the same enable-stall discipline.

---
 rtl/dif_bfu.sv | 131 +++++++++++++
 tb/tb_dif_bfu.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dif_bfu.sv
// Fixed-point formats shared by the FFT datapath.
package fft_consts;
    localparam int FP_BITS   = 16;
    localparam int FRAC_BITS = 14;

    typedef struct packed {
        logic signed [FP_BITS-1:0] r;
        logic signed [FP_BITS-1:0] i;
    } complex_t;
endpackage

// Radix-2 DIF butterfly: A' = A + B, B' = (A - B) * W, with conj(W) when inverse=1.
// Latency: 4 en-qualified cycles, fully pipelined, one operand pair per cycle.
// Backpressure: en=0 freezes every stage and the outputs; nothing is buffered internally.
module dif_bfu
    import fft_consts::*;
#(
    parameter bit SCALE_EN = 1'b0,
    parameter bit SATURATE = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    input  logic     in_valid,
    input  logic     inverse,
    input  complex_t A_in,
    input  complex_t B_in,
    input  complex_t W_in,
    input  logic     ovf_clr,
    output complex_t A_out,
    output complex_t B_out,
    output logic     out_valid,
    output logic     ovf
);
    localparam int SW = FP_BITS + 1;
    localparam int PW = 2 * FP_BITS + 2;
    localparam int SH = SCALE_EN ? 1 : 0;
    localparam logic signed [FP_BITS-1:0] MAX_V = {1'b0, {(FP_BITS-1){1'b1}}};
    localparam logic signed [FP_BITS-1:0] MIN_V = {1'b1, {(FP_BITS-1){1'b0}}};
    localparam logic signed [PW-1:0]      MAX_P = PW'(MAX_V);
    localparam logic signed [PW-1:0]      MIN_P = PW'(MIN_V);

    function automatic logic out_of_range(input logic signed [PW-1:0] v);
        return (v > MAX_P) || (v < MIN_P);
    endfunction

    function automatic logic signed [FP_BITS-1:0] fit(input logic signed [PW-1:0] v);
        if (SATURATE && (v > MAX_P)) return MAX_V;
        if (SATURATE && (v < MIN_P)) return MIN_V;
        return v[FP_BITS-1:0];
    endfunction

    complex_t              a_s1, b_s1, w_s1, w_s2;
    logic                  v_s1, v_s2, v_s3;
    logic signed [SW-1:0]  sr_s2, si_s2, dr_s2, di_s2, sr_s3, si_s3;
    logic signed [PW-1:0]  pr_s3, pi_s3;
    logic signed [PW-1:0]  pr_n, pi_n;
    logic signed [PW-1:0]  ar_sh, ai_sh, br_sh, bi_sh;
    logic signed [FP_BITS-1:0] wi_adj;
    logic                  any_oor;

    // -MIN_V has no representation, so conjugation pins it to MAX_V silently.
    always_comb begin
        wi_adj = W_in.i;
        if (inverse) wi_adj = (W_in.i == MIN_V) ? MAX_V : -W_in.i;
    end

    always_comb begin
        pr_n = PW'(dr_s2) * PW'(w_s2.r) - PW'(di_s2) * PW'(w_s2.i);
        pi_n = PW'(dr_s2) * PW'(w_s2.i) + PW'(di_s2) * PW'(w_s2.r);
    end

    assign ar_sh   = PW'(sr_s3) >>> SH;
    assign ai_sh   = PW'(si_s3) >>> SH;
    assign br_sh   = pr_s3 >>> (FRAC_BITS + SH);
    assign bi_sh   = pi_s3 >>> (FRAC_BITS + SH);
    assign any_oor = out_of_range(ar_sh) || out_of_range(ai_sh) ||
                     out_of_range(br_sh) || out_of_range(bi_sh);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_s1      <= 1'b0;
            v_s2      <= 1'b0;
            v_s3      <= 1'b0;
            out_valid <= 1'b0;
            a_s1      <= '0;
            b_s1      <= '0;
            w_s1      <= '0;
            w_s2      <= '0;
            sr_s2     <= '0;
            si_s2     <= '0;
            dr_s2     <= '0;
            di_s2     <= '0;
            sr_s3     <= '0;
            si_s3     <= '0;
            pr_s3     <= '0;
            pi_s3     <= '0;
            A_out     <= '0;
            B_out     <= '0;
        end else if (en) begin
            v_s1      <= in_valid;
            a_s1      <= A_in;
            b_s1      <= B_in;
            w_s1      <= '{r: W_in.r, i: wi_adj};

            v_s2      <= v_s1;
            sr_s2     <= SW'(a_s1.r) + SW'(b_s1.r);
            si_s2     <= SW'(a_s1.i) + SW'(b_s1.i);
            dr_s2     <= SW'(a_s1.r) - SW'(b_s1.r);
            di_s2     <= SW'(a_s1.i) - SW'(b_s1.i);
            w_s2      <= w_s1;

            v_s3      <= v_s2;
            sr_s3     <= sr_s2;
            si_s3     <= si_s2;
            pr_s3     <= pr_n;
            pi_s3     <= pi_n;

            out_valid <= v_s3;
            A_out     <= '{r: fit(ar_sh), i: fit(ai_sh)};
            B_out     <= '{r: fit(br_sh), i: fit(bi_sh)};
        end
    end

    // Clear is not gated by en; a same-cycle overflow event takes precedence.
    always_ff @(posedge clk) begin
        if (!rst_n)                      ovf <= 1'b0;
        else if (en && v_s3 && any_oor)  ovf <= 1'b1;
        else if (ovf_clr)                ovf <= 1'b0;
    end
endmodule

// File: tb/tb_dif_bfu.sv
`timescale 1ns/1ps
module tb_dif_bfu;
    import fft_consts::*;

    localparam int     NI = 4;
    localparam longint MX = (64'sd1 <<< (FP_BITS-1)) - 1;
    localparam longint MN = -MX - 1;
    localparam longint U  = 64'sd1 <<< FRAC_BITS;

    logic     clk = 1'b0;
    logic     rst_n, en, in_valid, inverse, ovf_clr;
    complex_t A_in, B_in, W_in;
    complex_t a_out [NI];
    complex_t b_out [NI];
    logic     out_valid [NI];
    logic     ovf [NI];

    always #5 clk = ~clk;

    // Instance g: SCALE_EN = g%2, SATURATE = (g<2).
    for (genvar g = 0; g < NI; g++) begin : g_dut
        dif_bfu #(.SCALE_EN(g % 2 == 1), .SATURATE(g < 2)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (in_valid),
            .inverse   (inverse),
            .A_in      (A_in),
            .B_in      (B_in),
            .W_in      (W_in),
            .ovf_clr   (ovf_clr),
            .A_out     (a_out[g]),
            .B_out     (b_out[g]),
            .out_valid (out_valid[g]),
            .ovf       (ovf[g])
        );
    end

    typedef struct { complex_t a; complex_t b; bit v; bit oor; } ent_t;

    ent_t pipe [NI][4];   // per instance: [0..2] in flight, [3] what the outputs must show
    bit   m_ovf [NI];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_on  = 1'b0;

    function automatic bit out_rng(longint x);
        return (x > MX) || (x < MN);
    endfunction

    function automatic longint fitv(longint x, bit sat);
        longint m;
        if (!out_rng(x)) return x;
        if (sat) return (x > MX) ? MX : MN;
        m = x % (64'sd1 <<< FP_BITS);
        if (m > MX) m = m - (64'sd1 <<< FP_BITS);
        if (m < MN) m = m + (64'sd1 <<< FP_BITS);
        return m;
    endfunction

    function automatic ent_t calc(int g, complex_t a, complex_t b, complex_t w, bit inv, bit v);
        ent_t   e;
        longint wr, wi, sr, si, dr, di, pr, pi, xar, xai, xbr, xbi;
        int     sh  = g % 2;
        bit     sat = (g < 2);
        wr = w.r;
        wi = w.i;
        if (inv) wi = (wi == MN) ? MX : -wi;
        sr = longint'(a.r) + longint'(b.r);
        si = longint'(a.i) + longint'(b.i);
        dr = longint'(a.r) - longint'(b.r);
        di = longint'(a.i) - longint'(b.i);
        pr = dr * wr - di * wi;
        pi = dr * wi + di * wr;
        xar = sr >>> sh;
        xai = si >>> sh;
        xbr = pr >>> (FRAC_BITS + sh);
        xbi = pi >>> (FRAC_BITS + sh);
        e.v   = v;
        e.oor = out_rng(xar) || out_rng(xai) || out_rng(xbr) || out_rng(xbi);
        e.a.r = FP_BITS'(fitv(xar, sat));
        e.a.i = FP_BITS'(fitv(xai, sat));
        e.b.r = FP_BITS'(fitv(xbr, sat));
        e.b.i = FP_BITS'(fitv(xbi, sat));
        return e;
    endfunction

    task automatic model_step();
        bit set;
        for (int g = 0; g < NI; g++) begin
            if (!rst_n) begin
                for (int s = 0; s < 4; s++) pipe[g][s] = '{a: '0, b: '0, v: 1'b0, oor: 1'b0};
                m_ovf[g] = 1'b0;
            end else begin
                set = 1'b0;
                if (en) begin
                    set = pipe[g][2].v && pipe[g][2].oor;
                    pipe[g][3] = pipe[g][2];
                    pipe[g][2] = pipe[g][1];
                    pipe[g][1] = pipe[g][0];
                    pipe[g][0] = calc(g, A_in, B_in, W_in, inverse, in_valid);
                end
                if (set)          m_ovf[g] = 1'b1;
                else if (ovf_clr) m_ovf[g] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int g = 0; g < NI; g++) begin
                n_tests++;
                if ({a_out[g], b_out[g], out_valid[g], ovf[g]} !==
                    {pipe[g][3].a, pipe[g][3].b, pipe[g][3].v, m_ovf[g]}) begin
                    n_fail++;
                    $display("FAIL model_cmp inst%0d @%0t: got A=(%0d,%0d) B=(%0d,%0d) v=%b ovf=%b, want A=(%0d,%0d) B=(%0d,%0d) v=%b ovf=%b",
                             g, $time, a_out[g].r, a_out[g].i, b_out[g].r, b_out[g].i, out_valid[g], ovf[g],
                             pipe[g][3].a.r, pipe[g][3].a.i, pipe[g][3].b.r, pipe[g][3].b.i, pipe[g][3].v, m_ovf[g]);
                end
            end
        end
    end

    task automatic chk(string nm, longint act, longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    task automatic chk_c(string nm, complex_t act, longint er, longint ei);
        n_tests++;
        if (longint'(act.r) !== er || longint'(act.i) !== ei) begin
            n_fail++;
            $display("FAIL %s: got (%0d,%0d), want (%0d,%0d)", nm, act.r, act.i, er, ei);
        end
    endtask

    function automatic complex_t cx(longint r, longint i);
        complex_t c;
        c.r = FP_BITS'(r);
        c.i = FP_BITS'(i);
        return c;
    endfunction

    function automatic complex_t rnd_cx();
        if ($urandom_range(0, 2) == 0) return cx(longint'($urandom) % (MX + 1), -longint'($urandom) % (MX + 2));
        return cx(longint'($urandom_range(0, 4000)) - 2000, longint'($urandom_range(0, 4000)) - 2000);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic issue(complex_t a, complex_t b, complex_t w, bit inv);
        A_in = a; B_in = b; W_in = w; inverse = inv; in_valid = 1'b1;
        tick();
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        complex_t got_a [12];
        complex_t got_b [12];
        complex_t snap_a, snap_b;
        int       n_got;

        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; inverse = 1'b0; ovf_clr = 1'b0;
        A_in = '0; B_in = '0; W_in = '0;
        tick();
        tick();
        chk_on = 1'b1;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rst_vld%0d", g), longint'(out_valid[g]), 0);
            chk($sformatf("rst_ovf%0d", g), longint'(ovf[g]), 0);
            chk_c($sformatf("rst_a%0d", g), a_out[g], 0, 0);
            chk_c($sformatf("rst_b%0d", g), b_out[g], 0, 0);
        end
        rst_n = 1'b1;
        en    = 1'b1;

        issue(cx(100, 50), cx(20, -10), cx(U, 0), 1'b0);
        idle(3);
        chk_c("basic_a", a_out[0], 120, 40);
        chk_c("basic_b", b_out[0], 80, 60);
        chk("basic_vld", longint'(out_valid[0]), 1);
        chk("basic_ovf", longint'(ovf[0]), 0);
        idle(1);
        chk("basic_vld_once", longint'(out_valid[0]), 0);

        issue(cx(0, 0), cx(100, 0), cx(0, U), 1'b0);
        issue(cx(0, 0), cx(100, 0), cx(0, U), 1'b1);
        idle(2);
        chk_c("conj_fwd_a", a_out[0], 100, 0);
        chk_c("conj_fwd_b", b_out[0], 0, -100);
        idle(1);
        chk_c("conj_inv_a", a_out[0], 100, 0);
        chk_c("conj_inv_b", b_out[0], 0, 100);

        issue(cx(101, 0), cx(0, 0), cx(U, 0), 1'b0);
        issue(cx(-101, 0), cx(0, 0), cx(U, 0), 1'b0);
        idle(2);
        chk_c("scale_pos_a", a_out[1], 50, 0);
        chk_c("scale_pos_b", b_out[1], 50, 0);
        idle(1);
        chk_c("scale_neg_a", a_out[1], -51, 0);
        chk_c("scale_neg_b", b_out[1], -51, 0);

        issue(cx(MX, 0), cx(MX, 0), cx(U, 0), 1'b0);
        idle(3);
        chk("sat_a", longint'(a_out[0].r), MX);
        chk("sat_ovf", longint'(ovf[0]), 1);
        chk("sat_scaled_a", longint'(a_out[1].r), MX);
        chk("sat_scaled_ovf", longint'(ovf[1]), 0);
        chk("wrap_a", longint'(a_out[2].r), -2);
        chk("wrap_ovf", longint'(ovf[2]), 1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_clr0", longint'(ovf[0]), 0);
        chk("ovf_clr2", longint'(ovf[2]), 0);

        // Three operands, en dropped for two cycles after the second; stalled inputs are junk.
        n_got = 0;
        for (int c = 0; c < 12; c++) begin
            en = !(c == 2 || c == 3);
            in_valid = 1'b0;
            if (c == 0 || c == 1 || c == 4) begin
                A_in = cx(100 + 10 * (c == 4 ? 2 : c), 50); B_in = cx(20, -10); W_in = cx(U, 0);
                inverse = 1'b0; in_valid = 1'b1;
            end else if (!en) begin
                A_in = cx(7, 7); B_in = cx(-3, 9); W_in = cx(5, 5); in_valid = 1'b1;
            end
            if (c == 2) begin snap_a = a_out[0]; snap_b = b_out[0]; end
            if (c == 4) begin
                chk_c("stall_hold_a", a_out[0], longint'(snap_a.r), longint'(snap_a.i));
                chk_c("stall_hold_b", b_out[0], longint'(snap_b.r), longint'(snap_b.i));
            end
            if (en && out_valid[0] && n_got < 12) begin
                got_a[n_got] = a_out[0];
                got_b[n_got] = b_out[0];
                n_got++;
            end
            tick();
        end
        en = 1'b1;
        chk("stall_count", n_got, 3);
        for (int k = 0; k < 3 && k < n_got; k++) begin
            chk_c($sformatf("stall_a%0d", k), got_a[k], 120 + 10 * k, 40);
            chk_c($sformatf("stall_b%0d", k), got_b[k], 80 + 10 * k, 60);
        end

        issue(cx(MX, MX), cx(MX, MX), cx(U, 0), 1'b0);
        issue(cx(MX, MX), cx(MX, MX), cx(U, 0), 1'b0);
        rst_n = 1'b0; in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_c("midrst_a", a_out[0], 0, 0);
        chk_c("midrst_b", b_out[0], 0, 0);
        chk("midrst_vld", longint'(out_valid[0]), 0);
        chk("midrst_ovf", longint'(ovf[0]), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("midrst_drain%0d", k), longint'(out_valid[0]) + longint'(ovf[0]), 0);
        end

        for (int c = 0; c < 600; c++) begin
            en       = ($urandom_range(0, 9) < 8);
            in_valid = $urandom_range(0, 1);
            inverse  = $urandom_range(0, 1);
            ovf_clr  = ($urandom_range(0, 19) == 0);
            A_in     = rnd_cx();
            B_in     = rnd_cx();
            case ($urandom_range(0, 3))
                0:       W_in = cx(U, 0);
                1:       W_in = cx(longint'($urandom_range(0, 2 * U)) - U, MN);
                default: W_in = cx(longint'($urandom_range(0, 2 * U)) - U, longint'($urandom_range(0, 2 * U)) - U);
            endcase
            tick();
        end
        en = 1'b1; ovf_clr = 1'b0;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
